// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nn_pkg
// Purpose  : Shared types and defaults for the network-core run checker.
//            Holds the controller state encoding, the default round size and
//            timeout limits, the datapath widths and a saturating increment
//            helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package nn_pkg;

  // Controller states. IDLE is the reset state; DONE holds the results.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_IDLE = 3'd1,
    GO        = 3'd2,
    RUN       = 3'd3,
    READ      = 3'd4,
    DRAIN     = 3'd5,
    DONE      = 3'd6
  } nn_state_t;

  localparam int NN_NUM_ENTRIES = 64;
  localparam int NN_GO_TIMEOUT  = 256;
  localparam int NN_RUN_TIMEOUT = 16'hFFFF;

  localparam int NN_ADDR_W = 12;
  localparam int NN_DATA_W = 16;
  localparam int NN_CNT_W  = 7;
  localparam int NN_CYC_W  = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [NN_CYC_W-1:0] nn_sat_inc(input logic [NN_CYC_W-1:0] v);
    return (v == {NN_CYC_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage : nn_pkg
`default_nettype wire

// File: rtl/nn_compare_counter.sv
`default_nettype none
// ============================================================================
// Module   : nn_compare_counter
// Purpose  : Compares two data words each enabled cycle and counts the number
//            of equal pairs in a register that saturates at all-ones.
// Ports    : clk     - clock, rising edge
//            reset   - synchronous active-high reset
//            clear   - synchronous clear of the count (start of a round)
//            enable  - a/b hold a valid pair this cycle
//            a, b    - data words to compare
//            count   - number of equal pairs since the last clear
// Revision : 1.0 - initial release
// ============================================================================
module nn_compare_counter #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [CNT_W-1:0]  count
);

  logic match;

  assign match = enable && (a == b);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (match && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule : nn_compare_counter
`default_nettype wire

// File: rtl/nn_run_checker.sv
`default_nettype none
// ============================================================================
// Module   : nn_run_checker
// Purpose  : Runs one round of the network core and grades its output.
//            A round waits for the core to be idle, pulses go until the core
//            reports busy, measures the run length, then reads the output and
//            golden SRAMs in lock-step and counts matching words.
// Ports    : clk, reset          - clock and synchronous active-high reset
//            start               - one-cycle round request (IDLE/DONE only)
//            ctrl_busy           - round in progress
//            go, busy            - handshake with the network core
//            out_read_address/   - output SRAM read port (1-cycle latency)
//            out_read_data
//            gold_read_address/  - golden SRAM read port (1-cycle latency)
//            gold_read_data
//            correct_count       - matching words in the last round
//            cycle_count         - cycles from go rise to busy fall
//            result_valid        - results stable
//            timeout             - last round aborted on a timeout
// Revision : 1.0 - initial release
// ============================================================================
module nn_run_checker
  import nn_pkg::*;
#(
  parameter int NUM_ENTRIES = NN_NUM_ENTRIES,
  parameter int GO_TIMEOUT  = NN_GO_TIMEOUT,
  parameter int RUN_TIMEOUT = NN_RUN_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 ctrl_busy,
  output logic                 go,
  input  logic                 busy,
  output logic [NN_ADDR_W-1:0] out_read_address,
  input  logic [NN_DATA_W-1:0] out_read_data,
  output logic [NN_ADDR_W-1:0] gold_read_address,
  input  logic [NN_DATA_W-1:0] gold_read_data,
  output logic [NN_CNT_W-1:0]  correct_count,
  output logic [NN_CYC_W-1:0]  cycle_count,
  output logic                 result_valid,
  output logic                 timeout
);

  localparam logic [31:0]          GO_LAST   = 32'(GO_TIMEOUT - 1);
  localparam logic [31:0]          RUN_LAST  = 32'(RUN_TIMEOUT - 1);
  localparam logic [NN_ADDR_W-1:0] ADDR_LAST = NN_ADDR_W'(NUM_ENTRIES - 1);

  nn_state_t            state;
  logic [31:0]          timer;     // cycles spent in the current GO or RUN wait
  logic [NN_ADDR_W-1:0] addr;      // shared read address, 0 outside READ
  logic                 cmp_en;    // SRAM data on the bus belongs to a READ address
  logic                 accept;

  assign accept = start && ((state == IDLE) || (state == DONE));

  assign out_read_address  = addr;
  assign gold_read_address = addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      go           <= 1'b0;
      ctrl_busy    <= 1'b0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      cycle_count  <= '0;
      addr         <= '0;
      timer        <= '0;
      cmp_en       <= 1'b0;
    end else begin
      // Read data lags its address by one cycle, so the compare window is
      // the READ window delayed by one (the last compare lands in DRAIN).
      cmp_en <= (state == READ);

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= WAIT_IDLE;
            ctrl_busy    <= 1'b1;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            cycle_count  <= '0;
          end
        end

        WAIT_IDLE: begin
          if (!busy) begin
            state <= GO;
            go    <= 1'b1;
            timer <= '0;
          end
        end

        GO: begin
          cycle_count <= nn_sat_inc(cycle_count);
          if (busy) begin
            state <= RUN;
            go    <= 1'b0;
            timer <= '0;
          end else if (timer == GO_LAST) begin
            state        <= DONE;
            go           <= 1'b0;
            timeout      <= 1'b1;
            ctrl_busy    <= 1'b0;
            result_valid <= 1'b1;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        RUN: begin
          // The busy-fall cycle is not counted, so cycle_count ends up equal
          // to the number of cycles from go rise to busy fall.
          if (!busy) begin
            state <= READ;
            addr  <= '0;
          end else begin
            cycle_count <= nn_sat_inc(cycle_count);
            if (timer == RUN_LAST) begin
              state        <= DONE;
              timeout      <= 1'b1;
              ctrl_busy    <= 1'b0;
              result_valid <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end

        READ: begin
          if (addr == ADDR_LAST) begin
            state <= DRAIN;
            addr  <= '0;
          end else begin
            addr <= addr + 1'b1;
          end
        end

        DRAIN: begin
          state        <= DONE;
          ctrl_busy    <= 1'b0;
          result_valid <= 1'b1;
        end

        default: begin
          state <= IDLE;
          go    <= 1'b0;
        end
      endcase
    end
  end

  nn_compare_counter #(
    .DATA_W(NN_DATA_W),
    .CNT_W (NN_CNT_W)
  ) u_compare (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .enable(cmp_en),
    .a     (out_read_data),
    .b     (gold_read_data),
    .count (correct_count)
  );

endmodule : nn_run_checker
`default_nettype wire

// File: tb/tb_nn_run_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_run_checker
// Purpose  : Directed self-checking bench for nn_run_checker. Models the two
//            SRAMs (one-cycle read latency) and drives the core busy line by
//            hand; expected values are hand-computed per scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nn_run_checker;
  import nn_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic        ctrl_busy;
  logic        go;
  logic        busy;
  logic [11:0] out_read_address;
  logic [15:0] out_read_data;
  logic [11:0] gold_read_address;
  logic [15:0] gold_read_data;
  logic [6:0]  correct_count;
  logic [15:0] cycle_count;
  logic        result_valid;
  logic        timeout;

  logic [15:0] out_mem  [64];
  logic [15:0] gold_mem [64];

  int total = 0;
  int bad   = 0;

  nn_run_checker dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .ctrl_busy        (ctrl_busy),
    .go               (go),
    .busy             (busy),
    .out_read_address (out_read_address),
    .out_read_data    (out_read_data),
    .gold_read_address(gold_read_address),
    .gold_read_data   (gold_read_data),
    .correct_count    (correct_count),
    .cycle_count      (cycle_count),
    .result_valid     (result_valid),
    .timeout          (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous SRAMs: data for an address appears in the following cycle.
  always @(posedge clk) begin
    out_read_data  <= out_mem[out_read_address[5:0]];
    gold_read_data <= gold_mem[gold_read_address[5:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Equal memories with a seed-dependent pattern, then corrupt chosen words.
  task automatic load(input int seed, input int d0, input int d1, input int d2);
    for (int i = 0; i < 64; i++) begin
      gold_mem[i] = 16'(i * 37 + seed);
      out_mem[i]  = gold_mem[i];
    end
    if (d0 >= 0) out_mem[d0] = ~gold_mem[d0];
    if (d1 >= 0) out_mem[d1] = ~gold_mem[d1];
    if (d2 >= 0) out_mem[d2] = ~gold_mem[d2];
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_go(input string tag);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (go) break;
    end
    check(tag, 32'(go), 32'd1);
  endtask

  // Called just after go has risen: busy rises 'rise' cycles later and
  // stays high for 'high' cycles.
  task automatic run_core(input int rise, input int high);
    repeat (rise) @(posedge clk);
    #1 busy = 1'b1;
    repeat (high) @(posedge clk);
    #1 busy = 1'b0;
  endtask

  task automatic wait_rv(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (result_valid) break;
      @(posedge clk); #1;
    end
    check(tag, 32'(result_valid), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    busy  = 1'b0;
    load(11, -1, -1, -1);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_go",        32'(go),                32'd0);
    check("rst_ctrl_busy", 32'(ctrl_busy),         32'd0);
    check("rst_rv",        32'(result_valid),      32'd0);
    check("rst_timeout",   32'(timeout),           32'd0);
    check("rst_correct",   32'(correct_count),     32'd0);
    check("rst_cycles",    32'(cycle_count),       32'd0);
    check("rst_out_addr",  32'(out_read_address),  32'd0);
    check("rst_gold_addr", 32'(gold_read_address), 32'd0);
    reset = 1'b0;

    // Round A: busy 2 cycles after go, high 100, all words equal
    do_start();
    check("a_ctrl_busy", 32'(ctrl_busy), 32'd1);
    wait_go("a_go");
    run_core(2, 100);
    @(posedge clk); #1;
    check("a_state_read", 32'(dut.state),        32'(READ));
    check("a_addr0",      32'(out_read_address), 32'd0);
    @(posedge clk); #1;
    check("a_addr1_out",  32'(out_read_address),  32'd1);
    check("a_addr1_gold", 32'(gold_read_address), 32'd1);
    check("a_rv_mid",     32'(result_valid),      32'd0);
    wait_rv("a_rv");
    check("a_correct",    32'(correct_count), 32'd64);
    check("a_cycles",     32'(cycle_count),   32'd102);
    check("a_timeout",    32'(timeout),       32'd0);
    check("a_ctrl_idle",  32'(ctrl_busy),     32'd0);
    check("a_addr_done",  32'(out_read_address), 32'd0);

    // Round B, back-to-back from DONE: words 5 and 63 differ
    load(200, 5, 63, -1);
    do_start();
    check("b_rv_cleared", 32'(result_valid), 32'd0);
    wait_go("b_go");
    run_core(2, 100);
    wait_rv("b_rv");
    check("b_correct", 32'(correct_count), 32'd62);
    check("b_cycles",  32'(cycle_count),   32'd102);

    // Round C, back-to-back: words 0,1,2 differ, different busy timing
    load(999, 0, 1, 2);
    do_start();
    wait_go("c_go");
    run_core(1, 20);
    wait_rv("c_rv");
    check("c_correct", 32'(correct_count), 32'd61);
    check("c_cycles",  32'(cycle_count),   32'd21);
    check("c_timeout", 32'(timeout),       32'd0);

    // Round D: busy never rises -> go held exactly 256 cycles
    do_start();
    wait_go("d_go");
    begin
      int n;
      n = 0;
      for (int i = 0; i < 400; i++) begin
        @(posedge clk); #1;
        n++;
        if (!go) break;
      end
      check("d_go_cycles", 32'(n), 32'd256);
    end
    check("d_timeout",   32'(timeout),       32'd1);
    check("d_rv",        32'(result_valid),  32'd1);
    check("d_correct",   32'(correct_count), 32'd0);
    check("d_cycles",    32'(cycle_count),   32'd256);
    check("d_ctrl_busy", 32'(ctrl_busy),     32'd0);

    // Round E: core still busy when start arrives
    load(42, -1, -1, -1);
    busy = 1'b1;
    do_start();
    repeat (4) @(posedge clk);
    #1;
    check("e_go_held",   32'(go),        32'd0);
    check("e_state_wait", 32'(dut.state), 32'(WAIT_IDLE));
    busy = 1'b0;
    check("e_go_same_cycle", 32'(go), 32'd0);
    @(posedge clk); #1;
    check("e_go_next", 32'(go), 32'd1);
    run_core(2, 100);
    wait_rv("e_rv");
    check("e_correct", 32'(correct_count), 32'd64);
    check("e_cycles",  32'(cycle_count),   32'd102);
    check("e_timeout", 32'(timeout),       32'd0);

    // Round F: reset pulsed 50 cycles into RUN, then a clean round
    do_start();
    wait_go("f_go");
    repeat (2) @(posedge clk);
    #1 busy = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("f_state_run", 32'(dut.state), 32'(RUN));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    busy  = 1'b0;
    check("f_rst_go",     32'(go),           32'd0);
    check("f_rst_ctrl",   32'(ctrl_busy),    32'd0);
    check("f_rst_state",  32'(dut.state),    32'(IDLE));
    check("f_rst_cycles", 32'(cycle_count),  32'd0);
    check("f_rst_rv",     32'(result_valid), 32'd0);
    load(7, 10, -1, -1);
    do_start();
    wait_go("g_go");
    run_core(3, 40);
    wait_rv("g_rv");
    check("g_correct", 32'(correct_count), 32'd63);
    check("g_cycles",  32'(cycle_count),   32'd43);
    check("g_timeout", 32'(timeout),       32'd0);

    // Start while the round is reading must be ignored
    load(3, -1, -1, -1);
    do_start();
    wait_go("h_go");
    run_core(2, 10);
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("h_state_read", 32'(dut.state), 32'(READ));
    wait_rv("h_rv");
    check("h_correct", 32'(correct_count), 32'd64);
    check("h_cycles",  32'(cycle_count),   32'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_nn_run_checker
`default_nettype wire

// File: doc/nn_run_checker.md
NN_RUN_CHECKER -- requirements
Module: nn_run_checker

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 64, number of output words compared per round.
REQ-002 SHALL have parameter GO_TIMEOUT, default 256, max cycles waiting for DUT busy to rise after go.
REQ-003 SHALL have parameter RUN_TIMEOUT, default 16'hFFFF, max cycles waiting for DUT busy to fall.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  one-cycle request to run one round.
REQ-007 SHALL have port ctrl_busy  output  1  high from accepted start until result_valid.
REQ-008 SHALL have port go  output  1  run request to the network core.
REQ-009 SHALL have port busy  input  1  network core busy.
REQ-010 SHALL have port out_read_address  output  12  output SRAM read address.
REQ-011 SHALL have port out_read_data  input  16  output SRAM data, valid one cycle after address.
REQ-012 SHALL have port gold_read_address  output  12  golden SRAM read address.
REQ-013 SHALL have port gold_read_data  input  16  golden SRAM data, valid one cycle after address.
REQ-014 SHALL have port correct_count  output  7  number of matching words in last round.
REQ-015 SHALL have port cycle_count  output  16  run cycles measured in last round.
REQ-016 SHALL have port result_valid  output  1  results of last round stable.
REQ-017 SHALL have port timeout  output  1  last round aborted on a timeout.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT_IDLE, GO, RUN, READ, DRAIN, DONE.
REQ-019 SHALL move IDLE->WAIT_IDLE on start=1; clear result_valid, timeout, correct_count, cycle_count in that cycle.
REQ-020 SHALL ignore start in every state except IDLE and DONE.
REQ-021 SHALL move WAIT_IDLE->GO in the first cycle busy=0.
REQ-022 SHALL hold go=1 in GO, only in GO; move GO->RUN in the cycle busy=1 is sampled.
REQ-023 SHALL in GO after GO_TIMEOUT cycles without busy=1 drop go, set timeout=1, go to DONE.
REQ-024 SHALL increment cycle_count every cycle in GO and RUN, saturating at 16'hFFFF.
REQ-025 SHALL move RUN->READ in the first cycle busy=0; cycle_count then equals cycles from go rise to busy fall.
REQ-026 SHALL in RUN after RUN_TIMEOUT cycles set timeout=1 and go to DONE without reading.
REQ-027 SHALL in READ drive the same address to both SRAMs, 0..NUM_ENTRIES-1, one per cycle, then enter DRAIN.
REQ-028 SHALL compare out_read_data to gold_read_data one cycle after each address; increment correct_count on equality.
REQ-029 SHALL in DRAIN complete the final compare, then enter DONE; READ+DRAIN lasts NUM_ENTRIES+1 cycles.
REQ-030 SHALL in DONE hold result_valid=1 and all results stable; start=1 in DONE behaves as start in IDLE.
REQ-031 SHALL drive read addresses 0 outside READ.
REQ-032 SHALL keep correct_count width sufficient for NUM_ENTRIES (64 fits 7 bits).

Reset
REQ-033 SHALL on reset=1 at any state, including mid-RUN or mid-READ, go to IDLE next edge.
REQ-034 SHALL reset go, ctrl_busy, result_valid, timeout, correct_count, cycle_count, addresses to 0.
REQ-035 SHALL give reset priority over start.

Structure
REQ-036 SHALL place the state enum and default NUM_ENTRIES/timeout constants in shared package nn_pkg.
REQ-037 SHALL contain one sub-module nn_compare_counter (registered equality + saturating match counter).

Verification
REQ-038 SHALL test: busy rises 2 cycles after go, falls 100 cycles later, all 64 words equal -> correct_count=64, cycle_count=102, timeout=0.
REQ-039 SHALL test: output words 5 and 63 differ from golden -> correct_count=62.
REQ-040 SHALL test: busy never rises -> go drops after 256 cycles, timeout=1, result_valid=1, correct_count=0.
REQ-041 SHALL test: reset pulsed at RUN cycle 50 -> next cycle go=0, ctrl_busy=0, state IDLE; later start runs cleanly.
REQ-042 SHALL test: busy=1 when start arrives -> go stays 0 until busy=0, then asserts next cycle.
REQ-043 SHALL test: two back-to-back rounds via start in DONE -> second round results independent of first.
